fb_scanout: RTL and testbench

- Consumes the timing outputs of the video signal generator: hcount, vcount, hs, vs, ad and nf.
- Reads a 4x-downscaled RGB565 frame buffer from an external BRAM and outputs 8-bit RGB.
- Delays the sync signals so they stay aligned with the pixel data; the outputs feed the TMDS encoders.
- Supports double buffering: buffer swaps happen only at the new-frame pulse, so a frame never tears.

---
 rtl/fb_pkg.sv | 33 +++
 rtl/pipe_delay.sv | 29 ++
 rtl/fb_scanout.sv | 148 ++++++++++++++
 tb/tb_fb_scanout.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer scanout block.
// Contents: RGB565 field positions, the 8-bit-per-channel pixel struct,
//           the end-to-end pipeline latency and the 565->888 expansion.
package fb_pkg;

    localparam int unsigned R_MSB = 15;
    localparam int unsigned R_LSB = 11;
    localparam int unsigned G_MSB = 10;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned B_MSB = 4;
    localparam int unsigned B_LSB = 0;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb888_t;

    // Address register + BRAM access + colour register.
    function automatic int unsigned calc_lat(input int unsigned read_latency);
        return read_latency + 32'd2;
    endfunction

    // Replicate the top bits into the vacated LSBs so full scale maps to 8'hFF.
    function automatic rgb888_t expand_565(input logic [15:0] d);
        rgb888_t p;
        p.red   = {d[R_MSB:R_LSB], d[R_MSB:R_MSB-2]};
        p.green = {d[G_MSB:G_LSB], d[G_MSB:G_MSB-1]};
        p.blue  = {d[B_MSB:B_LSB], d[B_MSB:B_MSB-2]};
        return p;
    endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with asynchronous reset to zero.
// Ports: clk_i/rst_i clock and async active-high reset,
//        d_i input sample, q_o the sample from DEPTH cycles earlier.
module pipe_delay #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fb_scanout.sv
// Frame-buffer scanout: turns video timing into BRAM reads of a downscaled
// RGB565 buffer and emits 8-bit RGB with sync delayed to match.
// Ports: pixel_clk_in/rst_in clock and async active-high reset;
//        hcount/vcount/hs/vs/ad/nf_in timing generator inputs;
//        swap_req_in producer request to show the other buffer;
//        fb_addr_out/fb_rd_en_out/fb_data_in BRAM read port;
//        red/green/blue_out pixel, hs/vs/ad/nf_out delayed timing;
//        disp_buf_out displayed buffer, swap_done_out swap pulse.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int unsigned ACTIVE_H_PIXELS = 1280,
    parameter int unsigned ACTIVE_LINES    = 720,
    parameter int unsigned SCALE_SHIFT     = 2,
    parameter int unsigned READ_LATENCY    = 2,
    parameter int unsigned H_W             = 11,
    parameter int unsigned V_W             = 10,
    localparam int unsigned FB_W = ACTIVE_H_PIXELS >> SCALE_SHIFT,
    localparam int unsigned FB_H = ACTIVE_LINES >> SCALE_SHIFT,
    localparam int unsigned LW   = $clog2(FB_W * FB_H),
    localparam int unsigned AW   = 1 + LW
) (
    input  logic           pixel_clk_in,
    input  logic           rst_in,
    input  logic [H_W-1:0] hcount_in,
    input  logic [V_W-1:0] vcount_in,
    input  logic           hs_in,
    input  logic           vs_in,
    input  logic           ad_in,
    input  logic           nf_in,
    input  logic           swap_req_in,
    output logic [AW-1:0]  fb_addr_out,
    output logic           fb_rd_en_out,
    input  logic [15:0]    fb_data_in,
    output logic [7:0]     red_out,
    output logic [7:0]     green_out,
    output logic [7:0]     blue_out,
    output logic           hs_out,
    output logic           vs_out,
    output logic           ad_out,
    output logic           nf_out,
    output logic           disp_buf_out,
    output logic           swap_done_out
);

    localparam int unsigned LAT = calc_lat(READ_LATENCY);

    logic [LW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_en_q, rd_en_d;
    logic          disp_buf_q, disp_buf_d;
    logic          pending_q, pending_d;
    logic          swap_done_q, swap_done_d;
    rgb888_t       rgb_q, rgb_d;

    logic          line_end;
    logic          swap_now;
    logic          ad_pre;
    logic [3:0]    sync_dly;
    logic          unused_vcount_bits;

    // Last pixel of the last display line that shares one frame-buffer row.
    assign line_end = ad_in
                   && (hcount_in == H_W'(ACTIVE_H_PIXELS - 1))
                   && (&vcount_in[SCALE_SHIFT-1:0]);
    assign swap_now = nf_in && (pending_q || swap_req_in);
    assign unused_vcount_bits = ^vcount_in[V_W-1:SCALE_SHIFT];

    // ad aligned with the data arriving at the colour register.
    pipe_delay #(.WIDTH(1), .DEPTH(LAT - 1)) u_ad_pre (
        .clk_i (pixel_clk_in),
        .rst_i (rst_in),
        .d_i   (ad_in),
        .q_o   (ad_pre)
    );

    pipe_delay #(.WIDTH(4), .DEPTH(LAT)) u_sync_dly (
        .clk_i (pixel_clk_in),
        .rst_i (rst_in),
        .d_i   ({hs_in, vs_in, ad_in, nf_in}),
        .q_o   (sync_dly)
    );

    // Next-state logic for addressing, buffer swap and colour.
    always_comb begin
        row_base_d  = row_base_q;
        addr_d      = {disp_buf_q, row_base_q + LW'(hcount_in >> SCALE_SHIFT)};
        rd_en_d     = ad_in;
        disp_buf_d  = disp_buf_q;
        pending_d   = pending_q;
        swap_done_d = swap_now;
        rgb_d       = '0;

        if (nf_in) begin
            row_base_d = '0;
        end else if (line_end) begin
            row_base_d = row_base_q + LW'(FB_W);
        end

        // A new frame consumes any outstanding request; a request landing
        // after the pulse waits for the next one.
        if (nf_in) begin
            pending_d = 1'b0;
            if (swap_now) begin
                disp_buf_d = ~disp_buf_q;
            end
        end else if (swap_req_in) begin
            pending_d = 1'b1;
        end

        if (ad_pre) begin
            rgb_d = expand_565(fb_data_in);
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            row_base_q  <= '0;
            addr_q      <= '0;
            rd_en_q     <= 1'b0;
            disp_buf_q  <= 1'b0;
            pending_q   <= 1'b0;
            swap_done_q <= 1'b0;
            rgb_q       <= '0;
        end else begin
            row_base_q  <= row_base_d;
            addr_q      <= addr_d;
            rd_en_q     <= rd_en_d;
            disp_buf_q  <= disp_buf_d;
            pending_q   <= pending_d;
            swap_done_q <= swap_done_d;
            rgb_q       <= rgb_d;
        end
    end

    assign fb_addr_out   = addr_q;
    assign fb_rd_en_out  = rd_en_q;
    assign red_out       = rgb_q.red;
    assign green_out     = rgb_q.green;
    assign blue_out      = rgb_q.blue;
    assign hs_out        = sync_dly[3];
    assign vs_out        = sync_dly[2];
    assign ad_out        = sync_dly[1];
    assign nf_out        = sync_dly[0];
    assign disp_buf_out  = disp_buf_q;
    assign swap_done_out = swap_done_q;

endmodule

// File: tb/tb_fb_scanout.sv
// Randomised bench for fb_scanout with a frame-level reference model and a
// behavioural BRAM holding random pixel data.
module tb_fb_scanout;

    localparam int unsigned LAT    = 4;
    localparam int unsigned MAXC   = 65536;
    localparam int unsigned H_LAST = 1279;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        hs = 1'b0, vs = 1'b0, ad = 1'b0, nf = 1'b0, swap_req = 1'b0;
    logic [16:0] fb_addr;
    logic        fb_rd_en;
    logic [15:0] fb_data = '0;
    logic [7:0]  red, green, blue;
    logic        hs_o, vs_o, ad_o, nf_o, disp_buf, swap_done;

    fb_scanout dut (
        .pixel_clk_in  (clk),
        .rst_in        (rst),
        .hcount_in     (hcount),
        .vcount_in     (vcount),
        .hs_in         (hs),
        .vs_in         (vs),
        .ad_in         (ad),
        .nf_in         (nf),
        .swap_req_in   (swap_req),
        .fb_addr_out   (fb_addr),
        .fb_rd_en_out  (fb_rd_en),
        .fb_data_in    (fb_data),
        .red_out       (red),
        .green_out     (green),
        .blue_out      (blue),
        .hs_out        (hs_o),
        .vs_out        (vs_o),
        .ad_out        (ad_o),
        .nf_out        (nf_o),
        .disp_buf_out  (disp_buf),
        .swap_done_out (swap_done)
    );

    always #5 clk = ~clk;

    // Two-cycle BRAM: address registered by the DUT, then two more stages.
    logic [15:0] mem [0:131071];
    logic [16:0] rd_addr_q = '0;
    always @(posedge clk) begin
        rd_addr_q <= fb_addr;
        fb_data   <= mem[rd_addr_q];
    end

    // Per-cycle history of driven inputs and model expectations.
    bit          h_ad [MAXC];
    bit          h_hs [MAXC];
    bit          h_vs [MAXC];
    bit          h_nf [MAXC];
    bit          h_buf [MAXC];
    bit          h_done [MAXC];
    bit          h_dir [MAXC];
    logic [16:0] h_addr [MAXC];
    logic [23:0] h_dir_rgb [MAXC];

    int n = 0;
    int reset_idx = 0;
    bit m_buf = 1'b0;
    bit m_pend = 1'b0;
    bit dir_en = 1'b0;
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n, got, exp);
        end
    endtask

    function automatic logic [23:0] expand(input logic [15:0] d);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(d) / 2048;
        g6 = (int'(d) / 32) % 64;
        b5 = int'(d) % 32;
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return {8'(r8), 8'(g8), 8'(b8)};
    endfunction

    function automatic bit live(input int i);
        return i >= reset_idx;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, 32'(fb_addr), 32'd0);
        check({tag, "_rd_en"}, 32'(fb_rd_en), 32'd0);
        check({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
        check({tag, "_sync"}, 32'({hs_o, vs_o, ad_o, nf_o}), 32'd0);
        check({tag, "_buf"}, 32'({disp_buf, swap_done}), 32'd0);
    endtask

    // Drive one cycle, record the expectation, then check the outputs.
    task automatic step(input int h, input int v, input bit a, input bit hsv,
                        input bit vsv, input bit nfv, input bit sw);
        int k, kk, j;
        logic [23:0] exp_rgb;
        k = n;
        if (k >= int'(MAXC) - 1) begin
            $display("FAIL cycle_budget cycle=%0d got=%0d expected<%0d", n, k, MAXC - 1);
            $fatal(1);
        end
        hcount = 11'(h);
        vcount = 10'(v);
        ad = a; hs = hsv; vs = vsv; nf = nfv; swap_req = sw;
        h_ad[k] = a; h_hs[k] = hsv; h_vs[k] = vsv; h_nf[k] = nfv;
        h_addr[k] = {m_buf, 16'((v / 4) * 320 + h / 4)};
        h_dir[k] = dir_en && v == 0 && h < 16 && (h % 4) == 0;
        case (h / 4)
            0: h_dir_rgb[k] = 24'hFF0000;
            1: h_dir_rgb[k] = 24'h00FF00;
            2: h_dir_rgb[k] = 24'h0000FF;
            default: h_dir_rgb[k] = 24'h080808;
        endcase
        if (nfv) begin
            h_done[k] = m_pend || sw;
            if (m_pend || sw) m_buf = !m_buf;
            m_pend = 1'b0;
        end else begin
            h_done[k] = 1'b0;
            if (sw) m_pend = 1'b1;
        end
        h_buf[k] = m_buf;

        @(posedge clk);
        #1;
        n++;

        kk = n - 1;
        check("rd_en", 32'(fb_rd_en), 32'(live(kk) && h_ad[kk]));
        if (live(kk) && h_ad[kk]) check("addr", 32'(fb_addr), 32'(h_addr[kk]));
        check("disp_buf", 32'(disp_buf), 32'(live(kk) && h_buf[kk]));
        check("swap_done", 32'(swap_done), 32'(live(kk) && h_done[kk]));

        j = n - int'(LAT);
        check("hs_out", 32'(hs_o), 32'(live(j) && h_hs[j]));
        check("vs_out", 32'(vs_o), 32'(live(j) && h_vs[j]));
        check("ad_out", 32'(ad_o), 32'(live(j) && h_ad[j]));
        check("nf_out", 32'(nf_o), 32'(live(j) && h_nf[j]));
        exp_rgb = (live(j) && h_ad[j]) ? expand(mem[h_addr[j]]) : 24'd0;
        check("rgb", 32'({red, green, blue}), 32'(exp_rgb));
        if (live(j) && h_dir[j]) check("rgb_direct", 32'({red, green, blue}), 32'(h_dir_rgb[j]));
    endtask

    task automatic line(input int v, input int p1, input int p2);
        for (int h = 0; h <= int'(H_LAST); h++) begin
            step(h, v, 1'b1, 1'b0, 1'b0, 1'b0, h == p1 || h == p2);
        end
        for (int i = 0; i < 8; i++) begin
            step(1280 + i, v, 1'b0, 1'(($urandom_range(0, 1))), 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic frame(input int nlines, input bit sw_at_nf, input bit sw_after, input int nreq);
        int p1, p2;
        step(0, 740, 1'b0, 1'b0, 1'b1, 1'b1, sw_at_nf);
        step(1, 740, 1'b0, 1'b0, 1'b1, 1'b0, sw_after);
        for (int i = 0; i < 4; i++) begin
            step(2 + i, 741, 1'b0, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), 1'b0, 1'b0);
        end
        for (int v = 0; v < nlines; v++) begin
            p1 = (nreq >= 1 && v == 0) ? int'($urandom_range(0, 600)) : -1;
            p2 = (nreq >= 2 && v == nlines - 1) ? int'($urandom_range(700, 1279)) : -1;
            line(v, p1, p2);
        end
    endtask

    initial begin
        for (int i = 0; i < 131072; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hF800;
        mem[1] = 16'h07E0;
        mem[2] = 16'h001F;
        mem[3] = 16'h0841;

        #2;
        check_all_zero("reset_state");
        #21;
        rst = 1'b0;

        // Row replication over nine lines plus fixed colour samples.
        dir_en = 1'b1;
        frame(9, 1'b0, 1'b0, 0);
        dir_en = 1'b0;
        // Two requests in a frame, one toggle at the next new frame.
        frame(2, 1'b0, 1'b0, 2);
        frame(2, 1'b0, 1'b0, 0);
        // Request coincident with nf swaps immediately.
        frame(2, 1'b1, 1'b0, 0);
        // Request right after nf is deferred one frame.
        frame(2, 1'b0, 1'b1, 0);
        frame(2, 1'b0, 1'b0, 0);

        // Asynchronous reset in the middle of an active line.
        step(0, 740, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int h = 0; h < 500; h++) step(h, 0, 1'b1, 1'b0, 1'b0, 1'b0, h == 100);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("reset_async");
        @(posedge clk);
        #3;
        rst = 1'b0;
        reset_idx = n;
        m_buf = 1'b0;
        m_pend = 1'b0;

        for (int f = 0; f < 8; f++) begin
            frame(int'($urandom_range(1, 2)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, int'($urandom_range(0, 2)));
        end
        step(0, 740, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1 + i, 740, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
